ov7670_cam_emu: RTL and testbench



---
 rtl/ov7670_emu_pkg.sv | 26 ++
 rtl/ov7670_emu_pattern.sv | 31 +++
 rtl/ov7670_cam_emu.sv | 161 ++++++++++++++++
 tb/tb_ov7670_cam_emu.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_emu_pkg.sv
// Shared types and constants for the OV7670 camera emulator.
package ov7670_emu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VSYNC  = 3'd1,
    VBACK  = 3'd2,
    ACTIVE = 3'd3,
    HBLANK = 3'd4,
    VFRONT = 3'd5
  } state_e;

  // Sized for the longest default interval (V_BACK_PCLKS).
  localparam int MAX_TIMING = 13328;
  localparam int TCNT_W     = $clog2(MAX_TIMING) + 1;

  // Pixel coordinate width; large enough for any supported image size.
  localparam int COORD_W = 12;

  // Colour-bar palette, index 0 is the leftmost bar.
  localparam logic [7:0][15:0] BAR_RGB = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

endpackage

// File: rtl/ov7670_emu_pattern.sv
// Combinational synthetic pattern generator: pixel coordinate and
// selected pattern to one RGB565 word.
module ov7670_emu_pattern
  import ov7670_emu_pkg::*;
#(
  parameter int C_IMG_COLS = 320
) (
  input  logic [COORD_W-1:0] col,
  input  logic [5:0]         row,
  input  logic [1:0]         sel,
  input  logic [15:0]        solid_rgb,
  input  logic [4:0]         frame_lsb,
  output logic [15:0]        rgb
);

  localparam int BAR_W = C_IMG_COLS / 8;

  logic [2:0] bar;
  assign bar = 3'(col / COORD_W'(BAR_W));

  always_comb begin
    rgb = 16'h0000;
    case (sel)
      2'd0:    rgb = BAR_RGB[bar];
      2'd1:    rgb = {col[4:0], row[5:0], frame_lsb};
      2'd2:    rgb = (col[3] ^ row[3]) ? 16'hFFFF : 16'h0000;
      default: rgb = solid_rgb;
    endcase
  end

endmodule

// File: rtl/ov7670_cam_emu.sv
// OV7670 parallel-bus emulator (RGB565, synthetic patterns).
// Optional macro CAM_EMU_FRAME_TAG_EN stamps pixel (0,0) with {A5, frame_cnt}.
module ov7670_cam_emu
  import ov7670_emu_pkg::*;
#(
  parameter int C_IMG_COLS    = 320,
  parameter int C_IMG_ROWS    = 240,
  parameter int PCLK_DIV      = 2,
  parameter int H_BLANK_PCLKS = 144,
  parameter int V_SYNC_PCLKS  = 2352,
  parameter int V_BACK_PCLKS  = 13328,
  parameter int V_FRONT_PCLKS = 7840
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  data,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic [2:0]  state_dbg
);

  localparam int DIV_W = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

  logic [DIV_W-1:0]   div_cnt;
  logic               div_wrap;
  logic               fall_tick;
  state_e             state, state_n;
  logic [TCNT_W-1:0]  tcnt, tcnt_n;
  logic [COORD_W-1:0] row, row_n;
  logic [COORD_W-1:0] col;
  logic [1:0]         sel_q;
  logic [15:0]        solid_q;
  logic               start, done;
  logic [15:0]        pat_rgb, pix;

  assign div_wrap  = (div_cnt == DIV_W'(PCLK_DIV - 1));
  assign fall_tick = div_wrap & pclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      pclk    <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      pclk    <= ~pclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // tcnt counts pclk periods within the current state; in ACTIVE it is the byte index.
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt + 1'b1;
    row_n   = row;
    start   = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE: begin
        tcnt_n = '0;
        if (enable) begin
          state_n = VSYNC;
          start   = 1'b1;
        end
      end
      VSYNC: if (tcnt == TCNT_W'(V_SYNC_PCLKS - 1)) begin
        state_n = VBACK;
        tcnt_n  = '0;
      end
      VBACK: if (tcnt == TCNT_W'(V_BACK_PCLKS - 1)) begin
        state_n = ACTIVE;
        tcnt_n  = '0;
        row_n   = '0;
      end
      ACTIVE: if (tcnt == TCNT_W'(2 * C_IMG_COLS - 1)) begin
        state_n = HBLANK;
        tcnt_n  = '0;
      end
      HBLANK: if (tcnt == TCNT_W'(H_BLANK_PCLKS - 1)) begin
        tcnt_n = '0;
        if (row == COORD_W'(C_IMG_ROWS - 1)) begin
          state_n = VFRONT;
        end else begin
          row_n   = row + 1'b1;
          state_n = ACTIVE;
        end
      end
      VFRONT: if (tcnt == TCNT_W'(V_FRONT_PCLKS - 1)) begin
        tcnt_n = '0;
        done   = 1'b1;
        if (enable) begin
          state_n = VSYNC;
          start   = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      row        <= '0;
      sel_q      <= 2'd0;
      solid_q    <= 16'h0000;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      frame_done <= fall_tick & done;
      if (fall_tick) begin
        state <= state_n;
        tcnt  <= tcnt_n;
        row   <= row_n;
        if (start) begin
          sel_q   <= pattern_sel;
          solid_q <= solid_rgb;
        end
        if (done) frame_cnt <= frame_cnt + 1'b1;
        // Back-to-back frames keep busy high across the boundary.
        if (start)     busy <= 1'b1;
        else if (done) busy <= 1'b0;
      end
    end
  end

  assign col = tcnt[COORD_W:1];

  ov7670_emu_pattern #(
    .C_IMG_COLS (C_IMG_COLS)
  ) u_pattern (
    .col       (col),
    .row       (row[5:0]),
    .sel       (sel_q),
    .solid_rgb (solid_q),
    .frame_lsb (frame_cnt[4:0]),
    .rgb       (pat_rgb)
  );

`ifdef CAM_EMU_FRAME_TAG_EN
  assign pix = (col == '0 && row == '0) ? {8'hA5, frame_cnt} : pat_rgb;
`else
  assign pix = pat_rgb;
`endif

  assign vsync     = (state == VSYNC);
  assign href      = (state == ACTIVE);
  assign data      = href ? (tcnt[0] ? pix[7:0] : pix[15:8]) : 8'h00;
  assign state_dbg = state;

endmodule

// File: tb/tb_ov7670_cam_emu.sv
// Self-checking bench for ov7670_cam_emu: per-pclk stream reference model,
// randomized patterns, reset/enable corner cases.
module tb_ov7670_cam_emu;

  localparam int COLS = 16;
  localparam int ROWS = 4;
  localparam int DIV  = 2;
  localparam int HB   = 4;
  localparam int VS   = 3;
  localparam int VB   = 5;
  localparam int VF   = 6;
  localparam int FRAME_CLKS = (VS + VB + ROWS * (2 * COLS + HB) + VF) * 2 * DIV;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic        pclk, vsync, href, busy, frame_done;
  logic [7:0]  data, frame_cnt;
  logic [2:0]  state_dbg;

  ov7670_cam_emu #(
    .C_IMG_COLS    (COLS),
    .C_IMG_ROWS    (ROWS),
    .PCLK_DIV      (DIV),
    .H_BLANK_PCLKS (HB),
    .V_SYNC_PCLKS  (VS),
    .V_BACK_PCLKS  (VB),
    .V_FRONT_PCLKS (VF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .pclk        (pclk),
    .vsync       (vsync),
    .href        (href),
    .data        (data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .state_dbg   (state_dbg)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: pixel word from coordinates and frame number
  function automatic logic [15:0] model_pix(input int c, input int r, input int f,
                                            input logic [1:0] sel, input logic [15:0] solid);
`ifdef CAM_EMU_FRAME_TAG_EN
    if (c == 0 && r == 0) return {8'hA5, 8'(f)};
`endif
    case (sel)
      2'd0:    return bars[c / (COLS / 8)];
      2'd1:    return 16'(((c % 32) << 11) | ((r % 64) << 5) | (f % 32));
      2'd2:    return ((((c / 8) % 2) ^ ((r / 8) % 2)) != 0) ? 16'hFFFF : 16'h0000;
      default: return solid;
    endcase
  endfunction

  // one entry {vsync, href, data} per pclk period of a frame
  task automatic push_frame(input int f, input logic [1:0] sel, input logic [15:0] solid);
    logic [15:0] p;
    for (int i = 0; i < VS; i++) exp_q.push_back(10'h200);
    for (int i = 0; i < VB; i++) exp_q.push_back(10'h000);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        p = model_pix(c, r, f, sel, solid);
        exp_q.push_back({2'b01, p[15:8]});
        exp_q.push_back({2'b01, p[7:0]});
      end
      for (int i = 0; i < HB; i++) exp_q.push_back(10'h000);
    end
    for (int i = 0; i < VF; i++) exp_q.push_back(10'h000);
  endtask

  // monitor: samples on clk falling edge, compares on every pclk rise
  int   frames_model = 0;
  int   done_cnt = 0;
  int   href_rises = 0;
  int   since_rise = 0;
  int   fd_w = 0;
  int   pix_cnt = 0;
  int   pix_match = 0;
  logic period_valid = 1'b0;
  logic in_frame = 1'b0;
  logic prev_pclk = 1'b0;
  logic prev_href = 1'b0;
  logic byte_ph = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic [7:0]  hi_byte = 8'h00;
  logic [15:0] mon_solid = 16'h0000;
  logic [9:0]  e;

  always @(negedge clk) begin
    if (rst) begin
      prev_pclk = 1'b0; prev_href = 1'b0; prev_data = 8'h00;
      period_valid = 1'b0; since_rise = 0; in_frame = 1'b0;
      byte_ph = 1'b0; fd_w = 0;
    end else begin
      if (pclk && !prev_pclk) begin
        if (period_valid) check("pclk_period", since_rise, 2 * DIV);
        period_valid = 1'b1;
        since_rise = 0;
        check("data_stable", data, prev_data);
        if (exp_q.size() > 0 && (in_frame || vsync)) begin
          in_frame = 1'b1;
          e = exp_q.pop_front();
          check("stream", {vsync, href, data}, e);
          if (exp_q.size() == 0) in_frame = 1'b0;
        end
        if (href) begin
          if (!byte_ph) hi_byte = data;
          else begin
            pix_cnt++;
            if ({hi_byte, data} == mon_solid) pix_match++;
          end
          byte_ph = ~byte_ph;
        end
      end
      if (href && !prev_href) href_rises++;
      if (frame_done) begin
        if (fd_w == 0) begin
          done_cnt++;
          check("frame_cnt", frame_cnt, 32'((frames_model + 1) % 256));
          frames_model++;
        end
        fd_w++;
      end else if (fd_w != 0) begin
        check("done_width", fd_w, 1);
        fd_w = 0;
      end
      prev_pclk = pclk;
      prev_href = href;
      prev_data = data;
      since_rise++;
    end
  end

  // driver tasks
  task automatic run_frames(input int n, input logic [1:0] sel, input logic [15:0] solid);
    int base, t;
    base = done_cnt;
    for (int i = 0; i < n; i++) push_frame(frames_model + i, sel, solid);
    pattern_sel = sel;
    solid_rgb   = solid;
    enable      = 1'b1;
    t = 0;
    if (n == 1) begin
      while (!busy && t < 100) begin @(negedge clk); t++; end
    end else begin
      while (done_cnt < base + n - 1 && t < n * FRAME_CLKS + 100) begin @(negedge clk); t++; end
    end
    enable = 1'b0;
    t = 0;
    while (done_cnt < base + n && t < FRAME_CLKS + 100) begin @(negedge clk); t++; end
    check("frames_done", done_cnt - base, n);
    check("busy_at_done", busy, 0);
    check("q_drain", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t, base, hr0, tog, saved;
    logic pp;
    logic [15:0] s;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_outs", {pclk, vsync, href, busy, frame_done}, 0);
    check("rst_data", data, 0);
    check("rst_fcnt", frame_cnt, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // colour bars, single frame
    run_frames(1, 2'd0, 16'h0000);

    // solid colour, pixel reconstruction
    pix_cnt = 0; pix_match = 0; mon_solid = 16'hF81F;
    run_frames(1, 2'd3, 16'hF81F);
    check("solid_pix_cnt", pix_cnt, ROWS * COLS);
    check("solid_pix_match", pix_match, ROWS * COLS);

    // three back-to-back frames, random pattern
    run_frames(3, 2'($urandom_range(0, 3)), 16'($urandom));

    // enable dropped and pattern changed in row 2
    push_frame(frames_model, 2'd1, 16'h0000);
    pattern_sel = 2'd1; enable = 1'b1;
    base = done_cnt; hr0 = href_rises; t = 0;
    while (href_rises < hr0 + 3 && t < FRAME_CLKS) begin @(negedge clk); t++; end
    enable = 1'b0; pattern_sel = 2'd0; solid_rgb = 16'($urandom);
    t = 0;
    while (done_cnt < base + 1 && t < FRAME_CLKS) begin @(negedge clk); t++; end
    check("d_frames", done_cnt - base, 1);
    check("d_busy", busy, 0);
    check("d_q_drain", exp_q.size(), 0);
    pp = pclk; tog = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pclk != pp) tog++;
      pp = pclk;
      if (i % 8 == 0) check("idle_out", {vsync, href, data, busy}, 0);
    end
    check("idle_pclk", tog, 20);
    check("idle_state", state_dbg, 0);

    // reset in the middle of ACTIVE
    s = 16'($urandom) | 16'h8001;
    push_frame(frames_model, 2'd3, s);
    pattern_sel = 2'd3; solid_rgb = s; enable = 1'b1;
    t = 0;
    while (!href && t < FRAME_CLKS) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    check("e_pre_href", href, 1);
    rst = 1'b1;
    #1;
    check("e_rst_ctl", {pclk, vsync, href, busy}, 0);
    check("e_rst_data", data, 0);
    check("e_rst_fcnt", frame_cnt, 0);
    exp_q.delete();
    in_frame = 1'b0;
    frames_model = 0;
    saved = done_cnt;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("e_no_done", done_cnt, saved);
    check("e_fcnt_hold", frame_cnt, 0);

    // two checker frames after reset (frame tag visible when enabled)
    run_frames(2, 2'd2, 16'h0000);

    // random tail
    for (int k = 0; k < 3; k++)
      run_frames(int'($urandom_range(1, 2)), 2'($urandom_range(0, 3)), 16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
